// File: rtl/float32_pkg.sv
// Shared binary32 field layout, constants and classification helpers.
package float32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_UN = 2'b10,
        CMP_LT = 2'b11
    } cmp_code_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float32_t;

    function automatic logic is_nan(input float32_t f);
        return (f.exp == '1) && (f.frac != '0);
    endfunction

    function automatic logic is_inf(input float32_t f);
        return (f.exp == '1) && (f.frac == '0);
    endfunction

    // Subnormals count as zero: this block flushes them everywhere.
    function automatic logic is_zero(input float32_t f);
        return f.exp == '0;
    endfunction

endpackage

// File: rtl/float_norm_round.sv
// Normalizes a magnitude by leading-zero count, rounds to nearest-even at
// 24 significant bits and packs a binary32 word. expIn is the biased
// exponent the value would have if its leading one sat in the top bit of mag.
module float_norm_round
    import float32_pkg::*;
#(
    parameter int MAG_W = 28
) (
    input  logic              sign,
    input  logic signed [9:0] expIn,
    input  logic [MAG_W-1:0]  mag,
    output logic [31:0]       result,
    output logic [7:0]        expNorm
);

    logic [5:0]        lzc;
    logic [MAG_W-1:0]  shifted;
    logic signed [9:0] expShift;
    logic signed [9:0] expFinal;
    logic [23:0]       sig;
    logic              roundBit;
    logic              stickyBit;
    logic              roundUp;
    logic [24:0]       sigRounded;
    logic [22:0]       frac;

    // Leading-zero count: the highest set bit wins because it is visited last.
    always_comb begin
        // NOTE: give every always_comb output a value before any branch, otherwise a missed path infers a latch.
        lzc = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (mag[i]) begin
                lzc = 6'(MAG_W - 1 - i);
            end
        end
    end

    // Shift, round-to-nearest-even, then pack with overflow/underflow handling.
    always_comb begin
        shifted    = mag << lzc;
        expShift   = expIn - $signed({4'b0000, lzc});
        sig        = shifted[MAG_W-1 -: 24];
        roundBit   = shifted[MAG_W-25];
        stickyBit  = |shifted[MAG_W-26:0];
        roundUp    = roundBit & (stickyBit | sig[0]);
        sigRounded = {1'b0, sig} + {24'b0, roundUp};
        expFinal   = expShift + $signed({9'b0, sigRounded[24]});
        frac       = sigRounded[24] ? sigRounded[23:1] : sigRounded[22:0];
        expNorm    = expShift[7:0];

        if (mag == '0) begin
            result = {sign, 31'b0};
        end else if (expFinal >= 10'sd255) begin
            result = {sign, 8'hFF, 23'b0};
        end else if (expFinal <= 10'sd0) begin
            result = 32'h0000_0000;
        end else begin
            result = {sign, expFinal[7:0], frac};
        end
    end

endmodule

// File: rtl/floating_add_compare_from_int.sv
// Combined binary32 add/subtract, signed-int-to-float and compare unit.
// Each function is transparent while its enable is high and otherwise
// replays the value captured at the last enabled clock edge.
module floating_add_compare_from_int
    import float32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        add_en,
    input  logic        add_sub,
    input  logic        conv_en,
    input  logic        cmp_en,
    output logic [31:0] add_result,
    output logic [31:0] conv_result,
    output logic [1:0]  cmp_result,
    output logic [31:0] debug
);

    localparam logic signed [9:0] CONV_EXP = 10'(BIAS + 31);

    float32_t fa;
    float32_t fb;
    logic     aNan, bNan, aInf, bInf, aZero, bZero;

    assign fa    = a;
    assign fb    = b;
    assign aNan  = is_nan(fa);
    assign bNan  = is_nan(fb);
    assign aInf  = is_inf(fa);
    assign bInf  = is_inf(fb);
    assign aZero = is_zero(fa);
    assign bZero = is_zero(fb);

    // ---------------- add / subtract: unpack and align ----------------
    logic              bSignEff;
    logic              effSub;
    logic [23:0]       mA, mB, mL, mS;
    logic [7:0]        expL, expS, expDiff;
    logic              aBigger;
    logic              signL;
    logic [4:0]        shiftAmt;
    logic [55:0]       smallWide;
    logic [27:0]       alignedBig, alignedSmall, addMag;
    logic              addSign;
    logic signed [9:0] addExpIn;
    logic [31:0]       addNorm;
    logic [7:0]        addExpNorm;
    logic [31:0]       addComb;

    assign bSignEff = fb.sign ^ add_sub;
    assign effSub   = fa.sign ^ bSignEff;
    assign mA       = aZero ? 24'b0 : {1'b1, fa.frac};
    assign mB       = bZero ? 24'b0 : {1'b1, fb.frac};
    assign aBigger  = (fa.exp > fb.exp) || ((fa.exp == fb.exp) && (mA >= mB));

    assign expL     = aBigger ? fa.exp : fb.exp;
    assign expS     = aBigger ? fb.exp : fa.exp;
    assign mL       = aBigger ? mA : mB;
    assign mS       = aBigger ? mB : mA;
    assign signL    = aBigger ? fa.sign : bSignEff;
    assign expDiff  = expL - expS;

    // Beyond 31 places the smaller operand only contributes to sticky.
    assign shiftAmt     = (expDiff > 8'd31) ? 5'd31 : expDiff[4:0];
    assign smallWide    = {mS, 32'b0} >> shiftAmt;
    // Layout: [27] carry, [26:3] significand, [2] guard, [1] round, [0] sticky.
    assign alignedBig   = {1'b0, mL, 3'b000};
    assign alignedSmall = {1'b0, smallWide[55:30], |smallWide[29:0]};
    assign addMag       = effSub ? (alignedBig - alignedSmall) : (alignedBig + alignedSmall);

    // Exact zero is +0 unless both addends were negative zeros.
    assign addSign  = (addMag == '0) ? (fa.sign & bSignEff) : signL;
    assign addExpIn = $signed({2'b00, expL}) + 10'sd1;

    float_norm_round #(.MAG_W(28)) u_addRound (
        .sign    (addSign),
        .expIn   (addExpIn),
        .mag     (addMag),
        .result  (addNorm),
        .expNorm (addExpNorm)
    );

    // Special operands override the arithmetic result.
    always_comb begin
        addComb = addNorm;
        if (aNan || bNan) begin
            addComb = QNAN;
        end else if (aInf && bInf) begin
            addComb = effSub ? QNAN : {fa.sign, 8'hFF, 23'b0};
        end else if (aInf) begin
            addComb = {fa.sign, 8'hFF, 23'b0};
        end else if (bInf) begin
            addComb = {bSignEff, 8'hFF, 23'b0};
        end
    end

    // ---------------- int-to-float ----------------
    logic [31:0] convAbs;
    logic [31:0] convComb;
    logic [7:0]  convExpNorm;

    // Two's-complement negate also maps 0x80000000 onto the exact 2^31 magnitude.
    assign convAbs = a[31] ? (~a + 32'd1) : a;

    float_norm_round #(.MAG_W(35)) u_convRound (
        .sign    (a[31]),
        .expIn   (CONV_EXP),
        .mag     ({convAbs, 3'b000}),
        .result  (convComb),
        .expNorm (convExpNorm)
    );

    // ---------------- compare ----------------
    logic      aNeg, bNeg;
    logic [30:0] aKey, bKey;
    cmp_code_t cmpComb;

    // Zeros (and flushed subnormals) compare as +0 with an all-zero key.
    assign aNeg = fa.sign & ~aZero;
    assign bNeg = fb.sign & ~bZero;
    assign aKey = aZero ? 31'b0 : a[30:0];
    assign bKey = bZero ? 31'b0 : b[30:0];

    // Sign-magnitude ordering; magnitude order flips for negative pairs.
    always_comb begin
        cmpComb = CMP_EQ;
        if (aNan || bNan) begin
            cmpComb = CMP_UN;
        end else if (aNeg != bNeg) begin
            cmpComb = aNeg ? CMP_LT : CMP_GT;
        end else if (aKey != bKey) begin
            cmpComb = ((aKey > bKey) ^ aNeg) ? CMP_GT : CMP_LT;
        end
    end

    // ---------------- hold registers and outputs ----------------
    logic [31:0] addHold;
    logic [31:0] convHold;
    cmp_code_t   cmpHold;

    // Capture each enabled result at the closing edge of its cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addHold  <= '0;
            convHold <= '0;
            cmpHold  <= CMP_EQ;
        end else begin
            // NOTE: non-blocking so every register samples values from before the edge.
            if (add_en)  addHold  <= addComb;
            if (conv_en) convHold <= convComb;
            if (cmp_en)  cmpHold  <= cmpComb;
        end
    end

    // Reset forces the ports to zero at once, even with an enable high.
    assign add_result  = !reset ? 32'h0 : (add_en  ? addComb  : addHold);
    assign conv_result = !reset ? 32'h0 : (conv_en ? convComb : convHold);
    assign cmp_result  = !reset ? 2'b00 : (cmp_en  ? cmpComb  : cmpHold);

    // ---------------- debug bus ----------------
    logic        anyEn;
    logic        convOnly;
    logic [31:0] debugWord;

    assign anyEn     = add_en | conv_en | cmp_en;
    assign convOnly  = conv_en & ~add_en & ~cmp_en;
    assign debugWord = {5'b0, cmp_en, conv_en, add_en,
                        convOnly ? 8'h00 : expDiff,
                        convOnly ? convExpNorm : addExpNorm,
                        8'h00};

    // Shared bus: release it whenever no function is active.
    assign debug = anyEn ? (reset ? debugWord : 32'h0) : 32'bz;

endmodule

// File: tb/tb_floating_add_compare_from_int.sv
// Scoreboard bench for floating_add_compare_from_int: every stimulus step
// queues its expected port values, which are popped and compared mid-cycle.
module tb_floating_add_compare_from_int;

    typedef enum int {P_ADD, P_CONV, P_CMP, P_DBG} port_t;

    typedef struct {
        string       tag;
        port_t       port;
        logic [31:0] value;
    } expect_t;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic        addSub;
        logic        addEn;
        logic        convEn;
        logic        cmpEn;
        port_t       port;
        logic [31:0] want;
    } vec_t;

    localparam logic [31:0] BUS_PATTERN = 32'hA55A_5AA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        add_en;
    logic        add_sub;
    logic        conv_en;
    logic        cmp_en;
    logic [31:0] add_result;
    logic [31:0] conv_result;
    logic [1:0]  cmp_result;
    wire  [31:0] debugBus;
    logic        tbDrive;

    expect_t sbq[$];
    int      assertCount = 0;
    int      failCount   = 0;

    always #5 clk = ~clk;

    // Second driver on the shared debug bus, used to prove the DUT lets go.
    assign debugBus = tbDrive ? BUS_PATTERN : 32'bz;

    floating_add_compare_from_int dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .add_en      (add_en),
        .add_sub     (add_sub),
        .conv_en     (conv_en),
        .cmp_en      (cmp_en),
        .add_result  (add_result),
        .conv_result (conv_result),
        .cmp_result  (cmp_result),
        .debug       (debugBus)
    );

    function automatic logic [31:0] observe(input port_t p);
        case (p)
            P_ADD:   return add_result;
            P_CONV:  return conv_result;
            P_CMP:   return {30'b0, cmp_result};
            default: return debugBus;
        endcase
    endfunction

    // Drive one stimulus step just after a rising edge and queue its expectation.
    task automatic applyVec(input vec_t v);
        @(posedge clk);
        #1;
        a       = v.a;
        b       = v.b;
        add_sub = v.addSub;
        add_en  = v.addEn;
        conv_en = v.convEn;
        cmp_en  = v.cmpEn;
        sbq.push_back('{v.tag, v.port, v.want});
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        tbDrive = 1'b0;
        a = '0; b = '0; add_sub = 1'b0;
        add_en = 1'b0; conv_en = 1'b0; cmp_en = 1'b0;
        #2;
        sbq.push_back('{"reset_add",  P_ADD,  32'h0});
        sbq.push_back('{"reset_conv", P_CONV, 32'h0});
        sbq.push_back('{"reset_cmp",  P_CMP,  32'h0});
        @(negedge clk);
        while (sbq.size() > 0) begin
            expect_t     e;
            logic [31:0] got;
            e   = sbq.pop_front();
            got = observe(e.port);
            assertCount++;
            if (got !== e.value) begin
                failCount++;
                $display("FAIL %s: observed 0x%08h, expected 0x%08h", e.tag, got, e.value);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_add();
        vec_t tbl[$];
        tbl.push_back('{"add_1p2",      32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 1'b0, P_ADD, 32'h4040_0000});
        tbl.push_back('{"add_hold",     32'h40A0_0000, 32'h4100_0000, 1'b0, 1'b0, 1'b0, 1'b0, P_ADD, 32'h4040_0000});
        tbl.push_back('{"sub_equal",    32'h3F80_0000, 32'h3F80_0000, 1'b1, 1'b1, 1'b0, 1'b0, P_ADD, 32'h0000_0000});
        tbl.push_back('{"sub_inf_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b1, 1'b0, 1'b0, P_ADD, 32'h7FC0_0000});
        tbl.push_back('{"tie_even",     32'h4B80_0000, 32'h3F80_0000, 1'b0, 1'b1, 1'b0, 1'b0, P_ADD, 32'h4B80_0000});
        tbl.push_back('{"tie_up",       32'h4B80_0000, 32'h4040_0000, 1'b0, 1'b1, 1'b0, 1'b0, P_ADD, 32'h4B80_0002});
        tbl.push_back('{"nan_in",       32'h7FC0_0000, 32'h3F80_0000, 1'b0, 1'b1, 1'b0, 1'b0, P_ADD, 32'h7FC0_0000});
        tbl.push_back('{"inf_plus_fin", 32'h7F80_0000, 32'h3F80_0000, 1'b0, 1'b1, 1'b0, 1'b0, P_ADD, 32'h7F80_0000});
        tbl.push_back('{"fin_sub_inf",  32'h3F80_0000, 32'h7F80_0000, 1'b1, 1'b1, 1'b0, 1'b0, P_ADD, 32'hFF80_0000});
        tbl.push_back('{"neg_zeros",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, P_ADD, 32'h8000_0000});
        tbl.push_back('{"overflow",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, P_ADD, 32'h7F80_0000});
        tbl.push_back('{"underflow",    32'h0080_0001, 32'h0080_0000, 1'b1, 1'b1, 1'b0, 1'b0, P_ADD, 32'h0000_0000});
        tbl.push_back('{"subnorm_flush",32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0, P_ADD, 32'h0000_0000});
        tbl.push_back('{"sticky_round", 32'h3F80_0000, 32'h3080_0000, 1'b1, 1'b1, 1'b0, 1'b0, P_ADD, 32'h3F80_0000});
        tbl.push_back('{"neg_result",   32'hC040_0000, 32'h3F80_0000, 1'b0, 1'b1, 1'b0, 1'b0, P_ADD, 32'hC000_0000});
        tbl.push_back('{"add_hold2",    32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0, P_ADD, 32'hC000_0000});
        foreach (tbl[i]) begin
            applyVec(tbl[i]);
            @(negedge clk);
            while (sbq.size() > 0) begin
                expect_t     e;
                logic [31:0] got;
                e   = sbq.pop_front();
                got = observe(e.port);
                assertCount++;
                if (got !== e.value) begin
                    failCount++;
                    $display("FAIL %s: observed 0x%08h, expected 0x%08h", e.tag, got, e.value);
                end
            end
        end
    endtask

    task automatic test_conv();
        vec_t tbl[$];
        tbl.push_back('{"conv_7",       32'h0000_0007, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, P_CONV, 32'h40E0_0000});
        tbl.push_back('{"conv_m1",      32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, P_CONV, 32'hBF80_0000});
        tbl.push_back('{"conv_max",     32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, P_CONV, 32'h4F00_0000});
        tbl.push_back('{"conv_min",     32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, P_CONV, 32'hCF00_0000});
        tbl.push_back('{"conv_zero",    32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, P_CONV, 32'h0000_0000});
        tbl.push_back('{"conv_tie_even",32'h0100_0001, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, P_CONV, 32'h4B80_0000});
        tbl.push_back('{"conv_tie_up",  32'h0100_0003, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, P_CONV, 32'h4B80_0002});
        tbl.push_back('{"conv_hold",    32'h0000_0055, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, P_CONV, 32'h4B80_0002});
        foreach (tbl[i]) begin
            applyVec(tbl[i]);
            @(negedge clk);
            while (sbq.size() > 0) begin
                expect_t     e;
                logic [31:0] got;
                e   = sbq.pop_front();
                got = observe(e.port);
                assertCount++;
                if (got !== e.value) begin
                    failCount++;
                    $display("FAIL %s: observed 0x%08h, expected 0x%08h", e.tag, got, e.value);
                end
            end
        end
    endtask

    task automatic test_compare();
        vec_t tbl[$];
        tbl.push_back('{"cmp_lt",       32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b1, P_CMP, 32'd3});
        tbl.push_back('{"cmp_gt",       32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1, P_CMP, 32'd1});
        tbl.push_back('{"cmp_zeros",    32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, P_CMP, 32'd0});
        tbl.push_back('{"cmp_nan_a",    32'h7FC0_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1, P_CMP, 32'd2});
        tbl.push_back('{"cmp_nan_b",    32'h3F80_0000, 32'h7F80_0001, 1'b0, 1'b0, 1'b0, 1'b1, P_CMP, 32'd2});
        tbl.push_back('{"cmp_neg_gt",   32'hBF80_0000, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 1'b1, P_CMP, 32'd1});
        tbl.push_back('{"cmp_sign_lt",  32'hC000_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1, P_CMP, 32'd3});
        tbl.push_back('{"cmp_inf_gt",   32'h7F80_0000, 32'h7F7F_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, P_CMP, 32'd1});
        tbl.push_back('{"cmp_subnorm",  32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, P_CMP, 32'd0});
        tbl.push_back('{"cmp_equal",    32'hBF80_0000, 32'hBF80_0000, 1'b0, 1'b0, 1'b0, 1'b1, P_CMP, 32'd0});
        tbl.push_back('{"cmp_lt2",      32'hBF80_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, P_CMP, 32'd3});
        tbl.push_back('{"cmp_hold",     32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0, P_CMP, 32'd3});
        foreach (tbl[i]) begin
            applyVec(tbl[i]);
            @(negedge clk);
            while (sbq.size() > 0) begin
                expect_t     e;
                logic [31:0] got;
                e   = sbq.pop_front();
                got = observe(e.port);
                assertCount++;
                if (got !== e.value) begin
                    failCount++;
                    $display("FAIL %s: observed 0x%08h, expected 0x%08h", e.tag, got, e.value);
                end
            end
        end
    endtask

    // All three functions active on consecutive cycles, then all released.
    task automatic test_back_to_back();
        vec_t tbl[$];
        tbl.push_back('{"b2b_add1",  32'h4000_0000, 32'h3F80_0000, 1'b1, 1'b1, 1'b1, 1'b1, P_ADD, 32'h3F80_0000});
        tbl.push_back('{"b2b_add2",  32'hFFFF_FFF9, 32'h40E0_0000, 1'b0, 1'b1, 1'b1, 1'b1, P_ADD, 32'h7FC0_0000});
        tbl.push_back('{"b2b_add3",  32'h1234_5678, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 1'b0, P_ADD, 32'h7FC0_0000});
        foreach (tbl[i]) begin
            applyVec(tbl[i]);
            case (i)
                0: begin
                    sbq.push_back('{"b2b_conv1", P_CONV, 32'h4E80_0000});
                    sbq.push_back('{"b2b_cmp1",  P_CMP,  32'd1});
                    sbq.push_back('{"b2b_dbg1",  P_DBG,  32'h0701_7F00});
                end
                1: begin
                    sbq.push_back('{"b2b_conv2", P_CONV, 32'hC0E0_0000});
                    sbq.push_back('{"b2b_cmp2",  P_CMP,  32'd2});
                end
                default: begin
                    sbq.push_back('{"b2b_conv3", P_CONV, 32'hC0E0_0000});
                    sbq.push_back('{"b2b_cmp3",  P_CMP,  32'd2});
                end
            endcase
            @(negedge clk);
            while (sbq.size() > 0) begin
                expect_t     e;
                logic [31:0] got;
                e   = sbq.pop_front();
                got = observe(e.port);
                assertCount++;
                if (got !== e.value) begin
                    failCount++;
                    $display("FAIL %s: observed 0x%08h, expected 0x%08h", e.tag, got, e.value);
                end
            end
        end
    endtask

    task automatic test_debug();
        vec_t tbl[$];
        tbl.push_back('{"dbg_add",  32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 1'b0, P_DBG, 32'h0101_8000});
        tbl.push_back('{"dbg_conv", 32'h0000_0007, 32'h4000_0000, 1'b0, 1'b0, 1'b1, 1'b0, P_DBG, 32'h0200_8100});
        tbl.push_back('{"dbg_float",32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0, P_DBG, BUS_PATTERN});
        foreach (tbl[i]) begin
            applyVec(tbl[i]);
            tbDrive = (i == 2);
            @(negedge clk);
            while (sbq.size() > 0) begin
                expect_t     e;
                logic [31:0] got;
                e   = sbq.pop_front();
                got = observe(e.port);
                assertCount++;
                if (got !== e.value) begin
                    failCount++;
                    $display("FAIL %s: observed 0x%08h, expected 0x%08h", e.tag, got, e.value);
                end
            end
        end
        tbDrive = 1'b0;
    endtask

    // Reset dropped mid-cycle with every enable high: ports clear at once
    // and the capture that edge would have made never happens.
    task automatic test_async_reset();
        for (int step = 0; step < 3; step++) begin
            @(posedge clk);
            #1;
            case (step)
                0: begin
                    a = 32'h3F80_0000; b = 32'h4000_0000; add_sub = 1'b0;
                    add_en = 1'b1; conv_en = 1'b1; cmp_en = 1'b1;
                    #2 reset = 1'b0;
                    #1;
                end
                1: begin
                    add_en = 1'b0; conv_en = 1'b0; cmp_en = 1'b0;
                    a = 32'h4000_0000; b = 32'h3F80_0000;
                end
                default: reset = 1'b1;
            endcase
            sbq.push_back('{$sformatf("rst%0d_add", step),  P_ADD,  32'h0});
            sbq.push_back('{$sformatf("rst%0d_conv", step), P_CONV, 32'h0});
            sbq.push_back('{$sformatf("rst%0d_cmp", step),  P_CMP,  32'h0});
            @(negedge clk);
            while (sbq.size() > 0) begin
                expect_t     e;
                logic [31:0] got;
                e   = sbq.pop_front();
                got = observe(e.port);
                assertCount++;
                if (got !== e.value) begin
                    failCount++;
                    $display("FAIL %s: observed 0x%08h, expected 0x%08h", e.tag, got, e.value);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_conv();
        test_compare();
        test_back_to_back();
        test_debug();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
